// File: rtl/bnn_pkg.sv
// Shared sizes and types for the binarized MLP classifier (784 -> 256 -> 10).
package bnn_pkg;
    localparam int N_IN   = 784;
    localparam int N_HID  = 256;
    localparam int N_OUT  = 10;
    localparam int TH_W   = 10;
    localparam int P1_W   = TH_W;
    localparam int P2_W   = 9;
    localparam int RES_W  = 4;
    localparam int STAGES = 3;

    typedef logic [N_HID-1:0] hid_t;
    typedef logic [P1_W-1:0]  p1_arr_t [N_HID];
    typedef logic [P2_W-1:0]  p2_arr_t [N_OUT];
endpackage

// File: rtl/bnn_if.sv
// Image/result bus plus the static weight and threshold buses of the classifier.
interface bnn_if;
    import bnn_pkg::*;

    logic                    i_valid;
    logic [N_IN-1:0]         i_data;
    logic [N_IN*N_HID-1:0]   i_weight_fc1;
    logic [N_HID*N_OUT-1:0]  i_weight_fc2;
    logic [TH_W*N_HID-1:0]   i_threshold;
    logic [RES_W-1:0]        o_result;
    logic                    o_valid;

    modport master (
        output i_valid, i_data, i_weight_fc1, i_weight_fc2, i_threshold,
        input  o_result, o_valid
    );

    modport slave (
        input  i_valid, i_data, i_weight_fc1, i_weight_fc2, i_threshold,
        output o_result, o_valid
    );
endinterface

// File: rtl/bnn_popcount.sv
// Combinational population count of a W-bit vector; result is $clog2(W+1) bits wide.
module bnn_popcount #(
    parameter  int W  = 784,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits_i,
    output logic [CW-1:0] count_o
);

    // Written as a linear reduction; synthesis rebalances it into an adder tree.
    always_comb begin
        count_o = '0;
        for (int k = 0; k < W; k++) begin
            count_o = count_o + CW'(bits_i[k]);
        end
    end

endmodule

// File: rtl/bnn.sv
// Fully pipelined binarized MLP: XNOR-popcount FC1 with thresholds, XNOR-popcount FC2, argmax.
module bnn
    import bnn_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    bnn_if.slave bus
);

    hid_t             hid_d;
    hid_t             hid_p1_q;
    p1_arr_t          pop1;
    p2_arr_t          pop2_d;
    p2_arr_t          pop2_p2_q;
    logic             vld_p1_q;
    logic             vld_p2_q;
    logic [RES_W-1:0] res_d;
    logic [RES_W-1:0] o_result_q;
    logic             o_valid_q;

    // Strict '>' keeps the earliest class on ties, giving lowest-index priority.
    function automatic logic [RES_W-1:0] argmax(input p2_arr_t p);
        logic [RES_W-1:0] idx;
        logic [P2_W-1:0]  best;
        idx  = '0;
        best = p[0];
        for (int c = 1; c < N_OUT; c++) begin
            if (p[c] > best) begin
                best = p[c];
                idx  = RES_W'(c);
            end
        end
        return idx;
    endfunction

    // ---- stage 1: hidden layer, one XNOR-popcount and threshold per neuron ----
    for (genvar n = 0; n < N_HID; n++) begin : g_fc1
        logic [N_IN-1:0] xnor_w;
        assign xnor_w = ~(bus.i_data ^ bus.i_weight_fc1[N_IN*n +: N_IN]);
        bnn_popcount #(.W(N_IN)) u_pc (
            .bits_i  (xnor_w),
            .count_o (pop1[n])
        );
        assign hid_d[n] = (pop1[n] >= bus.i_threshold[TH_W*n +: TH_W]);
    end

    // ---- stage 2: output layer scores ----
    for (genvar c = 0; c < N_OUT; c++) begin : g_fc2
        logic [N_HID-1:0] xnor_w;
        assign xnor_w = ~(hid_p1_q ^ bus.i_weight_fc2[N_HID*c +: N_HID]);
        bnn_popcount #(.W(N_HID)) u_pc (
            .bits_i  (xnor_w),
            .count_o (pop2_d[c])
        );
    end

    // ---- stage 3: argmax ----
    assign res_d = argmax(pop2_p2_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            o_valid_q  <= 1'b0;
            o_result_q <= '0;
        end else begin
            vld_p1_q  <= bus.i_valid;
            vld_p2_q  <= vld_p1_q;
            o_valid_q <= vld_p2_q;
            if (vld_p2_q) begin
                o_result_q <= res_d;
            end
        end
    end

    // Datapath registers run free; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        hid_p1_q  <= hid_d;
        pop2_p2_q <= pop2_d;
    end

    assign bus.o_result = o_result_q;
    assign bus.o_valid  = o_valid_q;

endmodule

// File: tb/tb_bnn.sv
// Bench for bnn: directed and randomized images against a behavioural classifier model.
module tb_bnn;
    import bnn_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bnn_if bus ();

    bnn dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [N_IN-1:0]  w1 [N_HID];
    logic [N_HID-1:0] w2 [N_OUT];
    logic [TH_W-1:0]  th [N_HID];

    int n_cmp;
    int n_bad;

    logic            vs [64];
    logic [N_IN-1:0] ds [64];
    logic [3:0]      er [64];
    logic            ov;
    logic [3:0]      ores;

    function automatic logic [N_IN-1:0] rand_img();
        logic [N_IN-1:0] v;
        logic [31:0]     r;
        r = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (i % 32 == 0) r = $urandom;
            v[i] = r[i % 32];
        end
        return v;
    endfunction

    function automatic logic [N_HID-1:0] rand_hid();
        logic [N_HID-1:0] v;
        for (int i = 0; i < N_HID / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic load();
        for (int n = 0; n < N_HID; n++) begin
            bus.i_weight_fc1[N_IN*n +: N_IN] = w1[n];
            bus.i_threshold[TH_W*n +: TH_W]  = th[n];
        end
        for (int c = 0; c < N_OUT; c++) bus.i_weight_fc2[N_HID*c +: N_HID] = w2[c];
    endtask

    task automatic randomize_net();
        for (int n = 0; n < N_HID; n++) begin
            w1[n] = rand_img();
            th[n] = TH_W'(372 + $urandom_range(0, 40));
        end
        for (int c = 0; c < N_OUT; c++) w2[c] = rand_hid();
        load();
    endtask

    // Reference classifier: count agreements, threshold, count again, pick first maximum.
    function automatic logic [3:0] model(input logic [N_IN-1:0] d);
        logic [N_HID-1:0] h;
        int best, bi, s;
        for (int n = 0; n < N_HID; n++) h[n] = ($countones(~(d ^ w1[n])) >= int'(th[n]));
        best = -1;
        bi   = 0;
        for (int c = 0; c < N_OUT; c++) begin
            s = $countones(~(h ^ w2[c]));
            if (s > best) begin
                best = s;
                bi   = c;
            end
        end
        return 4'(bi);
    endfunction

    task automatic tick(input logic v, input logic [N_IN-1:0] d,
                        output logic o_v, output logic [3:0] o_r);
        bus.i_valid = v;
        bus.i_data  = d;
        @(posedge clk);
        #1;
        o_v = bus.o_valid;
        o_r = bus.o_result;
    endtask

    task automatic test_reset();
        logic            ev;
        logic [3:0]      rv;
        rst_n = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick(1'b1, rand_img(), ov, ores);
            n_cmp++;
            if (ov !== 1'b0 || ores !== 4'd0) begin
                n_bad++;
                $display("FAIL reset_hold[%0d] o_valid=%b o_result=%0d, want 0/0", j, ov, ores);
            end
        end
        rst_n = 1'b1;
        vs[0] = 1'b1; ds[0] = rand_img(); er[0] = model(ds[0]);
        vs[1] = 1'b0; ds[1] = rand_img();
        for (int j = 0; j < 4; j++) begin
            tick((j < 2) ? vs[j] : 1'b0, (j < 2) ? ds[j] : '0, ov, ores);
            ev = (j >= 2) ? vs[j-2] : 1'b0;
            rv = (j >= 2) ? er[j-2] : 4'd0;
            n_cmp++;
            if (ov !== ev || (ev && ores !== rv)) begin
                n_bad++;
                $display("FAIL reset_first_latency[%0d] o_valid=%b o_result=%0d, want %b/%0d", j, ov, ores, ev, rv);
            end
        end
    endtask

    task automatic test_class_select();
        logic       ev;
        logic [3:0] rv;
        for (int n = 0; n < N_HID; n++) begin
            w1[n] = '0;
            th[n] = '0;
        end
        for (int c = 0; c < N_OUT; c++) w2[c] = (c == 7) ? '1 : '0;
        load();
        for (int i = 0; i < 3; i++) begin
            vs[i] = 1'b1;
            ds[i] = (i == 0) ? '0 : rand_img();
            er[i] = 4'd7;
        end
        for (int j = 0; j < 5; j++) begin
            tick((j < 3) ? vs[j] : 1'b0, (j < 3) ? ds[j] : '0, ov, ores);
            ev = (j >= 2) ? vs[j-2] : 1'b0;
            rv = (j >= 2) ? er[j-2] : 4'd0;
            n_cmp++;
            if (ov !== ev || (ev && ores !== rv)) begin
                n_bad++;
                $display("FAIL class_select[%0d] o_valid=%b o_result=%0d, want %b/%0d", j, ov, ores, ev, rv);
            end
        end
    endtask

    task automatic test_tie();
        logic             ev;
        logic [3:0]       rv;
        logic [N_HID-1:0] row;
        randomize_net();
        row = rand_hid();
        for (int c = 0; c < N_OUT; c++) w2[c] = row;
        load();
        for (int i = 0; i < 3; i++) begin
            vs[i] = 1'b1; ds[i] = rand_img(); er[i] = 4'd0;
        end
        for (int j = 0; j < 5; j++) begin
            tick((j < 3) ? vs[j] : 1'b0, (j < 3) ? ds[j] : '0, ov, ores);
            ev = (j >= 2) ? vs[j-2] : 1'b0;
            rv = (j >= 2) ? er[j-2] : 4'd0;
            n_cmp++;
            if (ov !== ev || (ev && ores !== rv)) begin
                n_bad++;
                $display("FAIL tie_all_equal[%0d] o_valid=%b o_result=%0d, want %b/%0d", j, ov, ores, ev, rv);
            end
        end
        for (int n = 0; n < N_HID; n++) th[n] = '0;
        for (int c = 0; c < N_OUT; c++) begin
            row = rand_hid();
            row[$urandom_range(0, N_HID-1)] = 1'b0;
            w2[c] = (c == 3 || c == 5) ? '1 : row;
        end
        load();
        for (int i = 0; i < 2; i++) begin
            vs[i] = 1'b1; ds[i] = rand_img(); er[i] = 4'd3;
        end
        for (int j = 0; j < 4; j++) begin
            tick((j < 2) ? vs[j] : 1'b0, (j < 2) ? ds[j] : '0, ov, ores);
            ev = (j >= 2) ? vs[j-2] : 1'b0;
            rv = (j >= 2) ? er[j-2] : 4'd0;
            n_cmp++;
            if (ov !== ev || (ev && ores !== rv)) begin
                n_bad++;
                $display("FAIL tie_3_5[%0d] o_valid=%b o_result=%0d, want %b/%0d", j, ov, ores, ev, rv);
            end
        end
    endtask

    // Hidden bits 1..255 forced to 1; fc2 rows 0 and 1 differ only in bit 0, so
    // the result is 0 when h[0]=1 and 1 when h[0]=0.
    task automatic test_threshold();
        logic            ev;
        logic [3:0]      rv;
        logic [N_IN-1:0] flip;
        for (int n = 0; n < N_HID; n++) begin
            w1[n] = rand_img();
            th[n] = '0;
        end
        th[0] = TH_W'(784);
        for (int c = 0; c < N_OUT; c++) w2[c] = '0;
        w2[0] = '1;
        w2[1] = '1;
        w2[1][0] = 1'b0;
        load();
        flip = w1[0];
        flip[$urandom_range(0, N_IN-1)] ^= 1'b1;
        vs[0] = 1'b1; ds[0] = w1[0]; er[0] = 4'd0;
        vs[1] = 1'b1; ds[1] = flip;  er[1] = 4'd1;
        for (int j = 0; j < 4; j++) begin
            tick((j < 2) ? vs[j] : 1'b0, (j < 2) ? ds[j] : '0, ov, ores);
            ev = (j >= 2) ? vs[j-2] : 1'b0;
            rv = (j >= 2) ? er[j-2] : 4'd0;
            n_cmp++;
            if (ov !== ev || (ev && ores !== rv)) begin
                n_bad++;
                $display("FAIL threshold_784[%0d] o_valid=%b o_result=%0d, want %b/%0d", j, ov, ores, ev, rv);
            end
        end
        th[0] = TH_W'(1023);
        load();
        vs[0] = 1'b1; ds[0] = w1[0]; er[0] = 4'd1;
        for (int j = 0; j < 3; j++) begin
            tick((j < 1) ? vs[j] : 1'b0, (j < 1) ? ds[j] : '0, ov, ores);
            ev = (j >= 2) ? vs[j-2] : 1'b0;
            rv = (j >= 2) ? er[j-2] : 4'd0;
            n_cmp++;
            if (ov !== ev || (ev && ores !== rv)) begin
                n_bad++;
                $display("FAIL threshold_1023[%0d] o_valid=%b o_result=%0d, want %b/%0d", j, ov, ores, ev, rv);
            end
        end
        th[0] = TH_W'(783);
        load();
        vs[0] = 1'b1; ds[0] = flip; er[0] = 4'd0;
        for (int j = 0; j < 3; j++) begin
            tick((j < 1) ? vs[j] : 1'b0, (j < 1) ? ds[j] : '0, ov, ores);
            ev = (j >= 2) ? vs[j-2] : 1'b0;
            rv = (j >= 2) ? er[j-2] : 4'd0;
            n_cmp++;
            if (ov !== ev || (ev && ores !== rv)) begin
                n_bad++;
                $display("FAIL threshold_783[%0d] o_valid=%b o_result=%0d, want %b/%0d", j, ov, ores, ev, rv);
            end
        end
    endtask

    task automatic test_bubbles();
        logic       ev;
        logic [3:0] rv;
        randomize_net();
        vs[0] = 1'b1; vs[1] = 1'b0; vs[2] = 1'b1; vs[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ds[i] = rand_img();
            er[i] = model(ds[i]);
        end
        for (int j = 0; j < 6; j++) begin
            tick((j < 4) ? vs[j] : 1'b0, (j < 4) ? ds[j] : '0, ov, ores);
            ev = (j >= 2) ? vs[j-2] : 1'b0;
            rv = (j >= 2) ? er[j-2] : 4'd0;
            n_cmp++;
            if (ov !== ev || (ev && ores !== rv)) begin
                n_bad++;
                $display("FAIL bubbles[%0d] o_valid=%b o_result=%0d, want %b/%0d", j, ov, ores, ev, rv);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic       ev;
        logic [3:0] rv;
        randomize_net();
        for (int i = 0; i < 40; i++) begin
            vs[i] = 1'b1;
            ds[i] = rand_img();
            er[i] = model(ds[i]);
        end
        for (int j = 0; j < 42; j++) begin
            tick((j < 40) ? vs[j] : 1'b0, (j < 40) ? ds[j] : '0, ov, ores);
            ev = (j >= 2) ? vs[j-2] : 1'b0;
            rv = (j >= 2) ? er[j-2] : 4'd0;
            n_cmp++;
            if (ov !== ev || (ev && ores !== rv) || ores > 4'd9) begin
                n_bad++;
                $display("FAIL back_to_back[%0d] o_valid=%b o_result=%0d, want %b/%0d", j, ov, ores, ev, rv);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic       ev;
        logic [3:0] rv;
        for (int j = 0; j < 3; j++) tick(1'b1, rand_img(), ov, ores);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.o_valid !== 1'b0 || bus.o_result !== 4'd0) begin
            n_bad++;
            $display("FAIL midstream_async_clear o_valid=%b o_result=%0d, want 0/0", bus.o_valid, bus.o_result);
        end
        tick(1'b0, '0, ov, ores);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick(1'b0, rand_img(), ov, ores);
            n_cmp++;
            if (ov !== 1'b0) begin
                n_bad++;
                $display("FAIL midstream_drained[%0d] o_valid=%b, want 0", j, ov);
            end
        end
        vs[0] = 1'b1; ds[0] = rand_img(); er[0] = model(ds[0]);
        for (int j = 0; j < 4; j++) begin
            tick((j < 1) ? vs[j] : 1'b0, (j < 1) ? ds[j] : '0, ov, ores);
            ev = (j == 2) ? vs[0] : 1'b0;
            rv = (j == 2) ? er[0] : 4'd0;
            n_cmp++;
            if (ov !== ev || (ev && ores !== rv)) begin
                n_bad++;
                $display("FAIL midstream_restart[%0d] o_valid=%b o_result=%0d, want %b/%0d", j, ov, ores, ev, rv);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        randomize_net();
        test_reset();
        test_class_select();
        test_tie();
        test_threshold();
        test_bubbles();
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
